gpi_input_filter: RTL
=====================

GPI_INPUT_FILTER -- requirements
Module: gpi_input_filter

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a level; legal range 1..65535.
REQ-003 PCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 PRESET  input  1  reset, asynchronous assert, active-high.
REQ-005 pin_in  input  WIDTH  raw asynchronous external pins.
REQ-006 bypass  input  1  synchronous; 1 = skip debounce, output follows synchronised pins.
REQ-007 gpi  output  WIDTH  filtered level; feeds the gpi port of the GPI peripheral directly.
REQ-008 rise  output  WIDTH  one-cycle pulse per bit when gpi bit goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per bit when gpi bit goes 1->0.

Function
REQ-010 Each pin_in bit passes a 2-flop synchroniser (s1, s2) before any other logic; no other logic uses pin_in.
REQ-011 Each bit has its own counter cnt[i], width clog2(DEBOUNCE_CYCLES+1), and its own registered gpi[i]; bits are fully independent.
REQ-012 Filter mode (bypass=0), per bit per edge: if s2[i]==gpi[i], cnt[i]<=0 and gpi[i] holds.
REQ-013 Filter mode, s2[i]!=gpi[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1, gpi[i] holds.
REQ-014 Filter mode, s2[i]!=gpi[i] and cnt[i]==DEBOUNCE_CYCLES-1: gpi[i]<=s2[i], cnt[i]<=0.
REQ-015 Any cycle with s2[i]==gpi[i] during counting (glitch) restarts cnt[i] at 0; no partial credit is kept.
REQ-016 Latency: pin change sampled at edge k makes gpi change at edge k+1+DEBOUNCE_CYCLES, provided the pin stays stable.
REQ-017 Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
REQ-018 DEBOUNCE_CYCLES=1: gpi[i] updates on the first edge on which s2[i]!=gpi[i] (equivalent to a one-cycle register after s2).
REQ-019 Bypass mode (bypass=1): gpi<=s2 every edge, all cnt<=0.
REQ-020 bypass switching 1->0: filtering resumes from cnt=0 with current gpi; switching 0->1: gpi takes s2 on the next edge, abandoning any in-progress count.
REQ-021 rise[i] and fall[i] are registered: high for exactly the one cycle following the edge on which gpi[i] changed, in both modes.
REQ-022 rise[i] and fall[i] are never high together; with no gpi change, both are 0.
REQ-023 Multiple bits may change or pulse in the same cycle, independently.

Reset
REQ-024 PRESET=1 immediately forces s1, s2, every cnt, gpi, rise and fall to 0, regardless of PCLK.
REQ-025 Reset asserted mid-count discards the count; after release, a pin held at 1 needs the full 2+DEBOUNCE_CYCLES edges to reach gpi.
REQ-026 No pulse on rise or fall is generated by reset assertion or release itself.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8, bypass=0 unless stated)
REQ-027 Reset release, pin_in=0x00 steady -> gpi=0x00, rise=fall=0x00 for 100 cycles.
REQ-028 pin_in 0x00->0x01 before edge 1, held -> gpi=0x01 after edge 6, rise=0x01 for exactly the cycle after edge 6, fall=0.
REQ-029 pin_in[3] pulses high for 3 cycles, then low -> gpi[3] stays 0, rise/fall remain 0.
REQ-030 pin_in[0] bounces 1,0,1,1,1,1 (one cycle each) -> counter restarts on the 0, gpi[0] rises only after 4 consecutive synchronised 1s; exactly one rise pulse.
REQ-031 bypass=1, pin_in 0xA5->0x5A -> gpi=0x5A two edges later, rise=0x5A and fall=0xA5 for one cycle.
REQ-032 pin_in=0xFF held, PRESET asserted 2 cycles into the count, then released -> gpi=0x00 immediately on assert; 0xFF after 6 edges post-release with one rise=0xFF pulse.

Source files
------------

// File: rtl/gpi_input_filter.sv
// Per-channel debounced GPI input filter: 2-flop synchroniser, stability counter,
// registered level plus one-cycle rise/fall pulses. Channels are fully independent.

module gpi_filter_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic pin,
  input  logic bypass,
  output logic gpi,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_gpi, r_rise, r_fall;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_gpi_nxt;

  // A single matching sample (glitch) throws away all accumulated credit.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_gpi_nxt = r_gpi;
    if (bypass) begin
      w_cnt_nxt = '0;
      w_gpi_nxt = r_s2;
    end else if (r_s2 == r_gpi) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == LAST) begin
      w_cnt_nxt = '0;
      w_gpi_nxt = r_s2;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cnt  <= '0;
      r_gpi  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= pin;
      r_s2   <= r_s1;
      r_cnt  <= w_cnt_nxt;
      r_gpi  <= w_gpi_nxt;
      r_rise <= w_gpi_nxt & ~r_gpi;
      r_fall <= ~w_gpi_nxt & r_gpi;
    end
  end

  assign gpi  = r_gpi;
  assign rise = r_rise;
  assign fall = r_fall;
endmodule

module gpi_input_filter #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             bypass,
  output logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpi_filter_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .pin    (pin_in[i]),
      .bypass (bypass),
      .gpi    (gpi[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end
endmodule
